// File: rtl/sasa_pkg.sv
// rtl/sasa_pkg.sv - shared constants and state type for the SASA input server
package sasa_pkg;
  localparam int SASA_Seq_len   = 16;
  localparam int SASA_Seq_shift = 4;
  localparam int SASA_Q_SHIFT   = 12;
  localparam int SASA_SAT_MIN   = -127;
  localparam int SASA_SAT_MAX   = 128;

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_SERVE = 1'b1
  } sasa_state_t;
endpackage

// File: rtl/sasa_quant.sv
// rtl/sasa_quant.sv - Q16.16 to x16 quantizer, round half away from zero; clamps when SASA_SAT_EN is defined
module sasa_quant
  import sasa_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_x,
  output logic [DATA_W-1:0] o_q
);
  localparam logic [DATA_W:0] HALF = (DATA_W+1)'(1) << (SASA_Q_SHIFT - 1);

  logic              w_neg;
  logic [DATA_W:0]   w_ext;
  logic [DATA_W:0]   w_mag;
  logic [DATA_W-1:0] w_rnd;
  logic [DATA_W-1:0] w_res;

  // One extra bit so negating the most negative input cannot overflow
  assign w_neg = i_x[DATA_W-1];
  assign w_ext = {i_x[DATA_W-1], i_x};
  assign w_mag = w_neg ? (~w_ext + 1'b1) : w_ext;
  assign w_rnd = DATA_W'((w_mag + HALF) >> SASA_Q_SHIFT);
  assign w_res = w_neg ? (~w_rnd + 1'b1) : w_rnd;

`ifdef SASA_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(SASA_SAT_MAX);
  localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(SASA_SAT_MIN);

  always_comb begin
    o_q = w_res;
    if ($signed(w_res) > SAT_HI) begin
      o_q = SAT_HI;
    end else if ($signed(w_res) < SAT_LO) begin
      o_q = SAT_LO;
    end
  end
`else
  assign o_q = w_res;
`endif
endmodule

// File: rtl/sasa_input_server.sv
// rtl/sasa_input_server.sv - loads a quantized SEQ_LEN x SEQ_LEN matrix, then serves 1-cycle reads (SASA_SAT_EN enables clamping)
module sasa_input_server
  import sasa_pkg::*;
#(
  parameter int SEQ_LEN = SASA_Seq_len,
  parameter int ADDR_W  = SASA_Seq_shift,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              clear,
  output logic              loaded,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr_x,
  input  logic [ADDR_W-1:0] data_addr_y,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              err
);
  localparam int              DEPTH = SEQ_LEN * SEQ_LEN;
  localparam int              CNT_W = 2 * ADDR_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  sasa_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ld_ready;
  logic              r_loaded;
  logic [DATA_W-1:0] r_data;
  logic              r_data_valid;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_q;
  logic              w_wr;
  logic              w_rd;
  logic [CNT_W-1:0]  w_addr;

  sasa_quant #(.DATA_W(DATA_W)) u_quant (
    .i_x (ld_data),
    .o_q (w_q)
  );

  // clear and reset both take priority over any beat or request in the same cycle
  assign w_wr   = reset && !clear && (r_state == S_LOAD) && ld_valid;
  assign w_rd   = reset && !clear && (r_state == S_SERVE) && data_req;
  assign w_addr = {data_addr_y, data_addr_x};

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_cnt] <= w_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_cnt        <= '0;
      r_ld_ready   <= 1'b1;
      r_loaded     <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_data_valid <= w_rd;
      r_data       <= w_rd ? r_mem[w_addr] : '0;
      if (clear) begin
        r_state    <= S_LOAD;
        r_cnt      <= '0;
        r_loaded   <= 1'b0;
        r_ld_ready <= 1'b1;
      end else begin
        if ((r_state == S_LOAD) && data_req) begin
          r_err <= 1'b1;
        end
        if (w_wr) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state    <= S_SERVE;
            r_loaded   <= 1'b1;
            r_ld_ready <= 1'b0;
          end
        end
      end
    end
  end

  assign ld_ready   = r_ld_ready;
  assign loaded     = r_loaded;
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign err        = r_err;
endmodule

// File: tb/tb_sasa_input_server.sv
// tb/tb_sasa_input_server.sv - scoreboard bench for sasa_input_server (honours SASA_SAT_EN)
module tb_sasa_input_server;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        clear;
  logic        loaded;
  logic        data_req;
  logic [3:0]  data_addr_x;
  logic [3:0]  data_addr_y;
  logic [31:0] data;
  logic        data_valid;
  logic        err;

  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

`ifdef SASA_SAT_EN
  localparam logic [31:0] E_POS = 32'd128;
  localparam logic [31:0] E_NEG = -32'sd127;
`else
  localparam logic [31:0] E_POS = 32'd160;
  localparam logic [31:0] E_NEG = -32'sd160;
`endif

  sasa_input_server dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .clear       (clear),
    .loaded      (loaded),
    .data_req    (data_req),
    .data_addr_x (data_addr_x),
    .data_addr_y (data_addr_y),
    .data        (data),
    .data_valid  (data_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h) at %0t",
               name, $signed(act), act, $signed(expv), expv, $time);
    end
  endtask

  // Monitor: every valid response pops one expectation; idle cycles must show data=0
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_resp: got %0d required no response at %0t", $signed(data), $time);
        end else begin
          chk("resp_data", data, exp_q.pop_front());
        end
      end else begin
        chk("idle_data", data, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_val(input int mode, input int i);
    logic [31:0] v;
    v = 32'd0;
    if (mode == 0) v = 32'(i * 4096);
    else if (mode == 1) v = 32'(i * 8192);
    else begin
      case (i)
        0: v = 32'h0001_8000;
        1: v = 32'h0000_0800;
        2: v = 32'h0000_07FF;
        3: v = 32'hFFFF_F800;
        4: v = 32'h000A_0000;
        5: v = 32'hFFF6_0000;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic load(input int mode, input int from, input int to);
    for (int i = from; i < to; i++) begin
      ld_valid = 1'b1;
      ld_data  = beat_val(mode, i);
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  task automatic req(input int x, input int y, input logic [31:0] expv);
    data_req    = 1'b1;
    data_addr_x = 4'(x);
    data_addr_y = 4'(y);
    exp_q.push_back(expv);
    tick();
    data_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld_ready"},   {31'd0, ld_ready},   32'd1);
    chk({tag, "_loaded"},     {31'd0, loaded},     32'd0);
    chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    chk({tag, "_data"},       data,                32'd0);
    chk({tag, "_err"},        {31'd0, err},        32'd0);
  endtask

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; clear = 1'b0;
    data_req = 1'b0; data_addr_x = '0; data_addr_y = '0;
    tick(); tick();
    chk_reset_outputs("reset");
    reset  = 1'b1;
    mon_en = 1'b1;

    // Rounding and saturation
    load(2, 0, 255);
    chk("load_not_done", {31'd0, loaded}, 32'd0);
    load(2, 255, 256);
    chk("loaded_set", {31'd0, loaded}, 32'd1);
    chk("ld_ready_drop", {31'd0, ld_ready}, 32'd0);
    req(0, 0, 32'd24);
    req(1, 0, 32'd1);
    req(2, 0, 32'd0);
    req(3, 0, 32'hFFFF_FFFF);
    req(4, 0, E_POS);
    req(5, 0, E_NEG);
    // Beats in S_SERVE must not disturb the matrix
    ld_valid = 1'b1; ld_data = 32'h7FFF_0000;
    tick(); tick();
    ld_valid = 1'b0; ld_data = '0;
    req(0, 0, 32'd24);
    tick();

    // Reset while serving and requesting: no response follows
    reset = 1'b0; data_req = 1'b1; data_addr_x = 4'd1;
    tick();
    data_req = 1'b0;
    chk_reset_outputs("serve_reset");
    reset = 1'b1;

    // Premature request during load
    load(0, 0, 50);
    data_req = 1'b1;
    load(0, 50, 51);
    data_req = 1'b0;
    tick();
    chk("err_premature", {31'd0, err}, 32'd1);
    load(0, 51, 256);
    chk("loaded_after_prem", {31'd0, loaded}, 32'd1);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Latency, addressing and back-to-back service
    req(3, 2, 32'd35);
    chk("lat_valid", {31'd0, data_valid}, 32'd1);
    tick();
    data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_addr_x = 4'((i * 7) % 16);
      data_addr_y = 4'((i * 5) % 16);
      exp_q.push_back(32'(((i * 5) % 16) * 16 + (i * 7) % 16));
      tick();
      chk("b2b_valid", {31'd0, data_valid}, 32'd1);
    end
    data_req = 1'b0;
    tick();
    chk("b2b_end", {31'd0, data_valid}, 32'd0);

    // clear beats data_req; err survives clear
    clear = 1'b1; data_req = 1'b1; data_addr_x = 4'd3; data_addr_y = 4'd2;
    tick();
    clear = 1'b0; data_req = 1'b0;
    chk("clr_loaded", {31'd0, loaded}, 32'd0);
    chk("clr_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("clr_no_resp", {31'd0, data_valid}, 32'd0);
    chk("clr_err_kept", {31'd0, err}, 32'd1);
    // clear with a beat: the beat is dropped
    clear = 1'b1; ld_valid = 1'b1; ld_data = 32'h7FFF_0000;
    tick();
    clear = 1'b0; ld_valid = 1'b0;
    load(1, 0, 255);
    chk("reload_not_done", {31'd0, loaded}, 32'd0);
    load(1, 255, 256);
    chk("reload_done", {31'd0, loaded}, 32'd1);
    req(3, 2, 32'd70);
    req(0, 0, 32'd0);
    req(15, 15, 32'd510);
    tick();

    // Reset mid-load
    reset = 1'b0;
    tick();
    reset = 1'b1;
    load(0, 0, 100);
    reset = 1'b0; ld_valid = 1'b1; ld_data = 32'h0001_0000;
    tick();
    ld_valid = 1'b0;
    chk_reset_outputs("midload_reset");
    reset = 1'b1;
    load(0, 0, 255);
    chk("rst_reload_not_done", {31'd0, loaded}, 32'd0);
    load(0, 255, 256);
    chk("rst_reload_done", {31'd0, loaded}, 32'd1);
    req(3, 2, 32'd35);
    tick(); tick();

    mon_en = 1'b0;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
